// File: rtl/instr_fetch_feeder.sv
// ============================================================================
// Module      : instr_fetch_feeder
// Description : Fetches program-order words from a synchronous instruction
//               memory into a small FIFO. It presents the two oldest words to
//               the dual-issue scheduler and retires them according to the
//               freeze signals. Optional macro: FETCH_HALT_ON_ZERO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_feeder #(
    parameter int DEPTH    = 8,
    parameter int IMEM_AW  = 10,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               freeze1,
    input  logic               freeze2,
    input  logic               redirect,
    input  logic [IMEM_AW-1:0] redirect_pc,
    output logic [31:0]        instruction0,
    output logic [31:0]        instruction1,
    output logic               nothing_filled
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_STALL = 2'd1
`ifdef FETCH_HALT_ON_ZERO_EN
        , S_HALT = 2'd2
`endif
    } state_t;

    logic [31:0]        r_mem [DEPTH];
    logic [IMEM_AW-1:0] r_pc;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW-1:0]      r_wr_ptr;
    logic [CW-1:0]      r_count;
    logic               r_inflight;
    state_t             r_state;

    state_t             w_state_next;
    logic [1:0]         w_pop_raw;
    logic [CW-1:0]      w_pop;
    logic [CW:0]        w_occ;
    logic               w_space;
    logic               w_push;
    logic               w_can_fetch;
    logic               w_req;
    logic [AW-1:0]      w_rd1_ptr;

    // In-order issue: slot 1 can only retire if slot 0 retires too.
    always_comb begin
        w_pop_raw = 2'd2;
        if (freeze1) begin
            w_pop_raw = 2'd0;
        end else if (freeze2) begin
            w_pop_raw = 2'd1;
        end
        w_pop = {{(CW-2){1'b0}}, w_pop_raw};
        if (w_pop > r_count) begin
            w_pop = r_count;
        end
    end

`ifdef FETCH_HALT_ON_ZERO_EN
    logic w_halt_hit;
    assign w_halt_hit = r_inflight && (imem_rdata == 32'd0);
    assign w_push     = r_inflight && (imem_rdata != 32'd0);
`else
    assign w_push     = r_inflight;
`endif

    // Occupancy once this cycle's push/pop settle; a new request needs a free slot.
    assign w_occ   = {1'b0, r_count} + {{CW{1'b0}}, r_inflight} - {1'b0, w_pop};
    assign w_space = (w_occ < (CW+1)'(DEPTH));

    always_comb begin
        w_state_next = r_state;
        w_can_fetch  = 1'b0;
        case (r_state)
            S_FETCH, S_STALL: begin
`ifdef FETCH_HALT_ON_ZERO_EN
                w_can_fetch = w_space && !w_halt_hit;
                if (w_halt_hit) begin
                    w_state_next = S_HALT;
                end else
`else
                w_can_fetch = w_space;
`endif
                if (w_space) begin
                    w_state_next = S_FETCH;
                end else begin
                    w_state_next = S_STALL;
                end
            end
`ifdef FETCH_HALT_ON_ZERO_EN
            S_HALT: begin
                w_state_next = S_HALT;
            end
`endif
            default: begin
                w_state_next = S_FETCH;
            end
        endcase
    end

    assign w_req     = en && !rst && !redirect && w_can_fetch;
    assign imem_req  = w_req;
    assign imem_addr = r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= IMEM_AW'(RESET_PC);
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_state    <= S_FETCH;
        end else if (en) begin
            if (redirect) begin
                r_pc       <= redirect_pc;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
                r_inflight <= 1'b0;
                r_state    <= S_FETCH;
            end else begin
                r_state    <= w_state_next;
                r_inflight <= w_req;
                if (w_req) begin
                    r_pc <= r_pc + IMEM_AW'(1);
                end
                r_rd_ptr <= r_rd_ptr + w_pop[AW-1:0];
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                r_count <= r_count + {{(CW-1){1'b0}}, w_push} - w_pop;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && en && !redirect && w_push) begin
            r_mem[r_wr_ptr] <= imem_rdata;
        end
    end

    assign w_rd1_ptr      = r_rd_ptr + AW'(1);
    assign instruction0   = (r_count != '0) ? r_mem[r_rd_ptr] : 32'd0;
    assign instruction1   = (r_count > CW'(1)) ? r_mem[w_rd1_ptr] : 32'd0;
    assign nothing_filled = (r_count == '0);

endmodule

`default_nettype wire

// File: doc/instr_fetch_feeder.md
Name: instr_fetch_feeder

Overview:
- Producer side of the dual-issue instruction interface (instruction0/instruction1, freeze1/freeze2, nothing_filled) that the scheduling control unit consumes.
- Fetches 32-bit words from a synchronous instruction memory in program order and buffers them in a small FIFO.
- Presents the two oldest words to the scheduler and retires 0, 1 or 2 of them per enabled cycle, according to the freeze signals.
- Steps only on the divided clock-enable (en), like the rest of the core.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 4.
- IMEM_AW, 10, word-address width of the instruction memory.
- RESET_PC, 0, word address of the first fetch after reset.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high; overrides en.
- en  input  1  clock enable; all state advances only on clk edges with en=1.
- imem_req  output  1  fetch request this enabled cycle.
- imem_addr  output  IMEM_AW  word address of the request.
- imem_rdata  input  32  read data; valid on the enabled cycle after the request.
- freeze1  input  1  scheduler holds slot 0 (no retire).
- freeze2  input  1  scheduler holds slot 1.
- redirect  input  1  flush the buffer and restart fetch.
- redirect_pc  input  IMEM_AW  new fetch address on redirect.
- instruction0  output  32  oldest buffered word; 32'd0 if count==0.
- instruction1  output  32  second-oldest word; 32'd0 if count<2.
- nothing_filled  output  1  1 when count==0.

Behaviour:
- Reset (rst=1 at a clk edge, regardless of en):
  - pc=RESET_PC, count=0, inflight=0, state=FETCH.
  - Outputs: imem_req=0, imem_addr=RESET_PC, instruction0=instruction1=0, nothing_filled=1.
- FIFO:
  - Circular buffer with rd_ptr/wr_ptr of width clog2(DEPTH); both wrap modulo DEPTH.
  - count is clog2(DEPTH)+1 bits wide.
  - instruction0/1 are combinational reads of entries rd_ptr and rd_ptr+1 (mod DEPTH), zero-gated by count.
- Retire (pop) count per enabled cycle:
  - freeze1=1 -> 0; freeze2 is ignored (in-order issue).
  - freeze1=0, freeze2=1 -> 1.
  - freeze1=0, freeze2=0 -> 2.
  - Pop is clamped to count (count=1 with no freezes pops 1; count=0 pops 0).
- Fetch:
  - imem_req=1 in state FETCH when count + inflight - pop < DEPTH; at most one request per enabled cycle.
  - On a request, pc increments by 1, wrapping modulo 2^IMEM_AW.
  - inflight (0/1) marks a request whose data returns next enabled cycle. That data is pushed at wr_ptr in the same cycle as any pop: net count = count + push - pop.
- Full: when no space is available, state=STALL with imem_req=0. Return to FETCH when space exists; a simultaneous pop counts as space in the same cycle.
- FSM states: FETCH, STALL, HALT (HALT exists only with the optional feature).
- Redirect (en=1) has priority over push, pop and fetch:
  - count=0, pointers reset, inflight data discarded, pc=redirect_pc, state=FETCH.
  - No request is issued in the redirect cycle.
  - The first request for redirect_pc is issued on the next enabled cycle.
- en=0: all state holds; imem_req forced to 0; combinational outputs still reflect the held state.
- Reset mid-fetch: inflight data is discarded; no push occurs after reset.
- Latency: after reset, the first word appears on instruction0 two enabled cycles after the first request (request, then push).

Optional Feature:
- Macro: FETCH_HALT_ON_ZERO_EN.
- Defined:
  - A returned word equal to 32'd0 is not pushed; state=HALT.
  - In HALT, imem_req=0 and the buffer continues to drain normally.
  - Only rst or redirect leaves HALT.
- Not defined:
  - Zero words are pushed like any other word; no HALT state is built.
  - The scheduler treats such words as bubbles.

Test Plan:
- Reset then en=1 every cycle, memory word[i]=i+1, freeze1=freeze2=1 -> requests at addresses 0..7, then stall; count=8; instruction0=1, instruction1=2; imem_req=0.
- From full, freeze1=0, freeze2=0 for one cycle -> instruction0=3, instruction1=4; imem_req reasserts the same cycle with address 8.
- freeze1=0, freeze2=1 repeatedly with steady fetch -> one retire per cycle; instruction0 steps 1,2,3,...; instruction1 always equals instruction0+1.
- redirect=1, redirect_pc=0x3F0 while count=5 with a request in flight -> next cycle nothing_filled=1, outputs 0, and the in-flight word is not pushed. Then addresses 0x3F0..0x3FF, 0x000 are fetched (wrap).
- en toggled 1,0,0,1 -> state frozen during en=0 and imem_req=0; progress resumes identically.
- With FETCH_HALT_ON_ZERO_EN, word[3]=0 -> words 1,2,3 delivered, then state=HALT, nothing_filled=1 after drain, no further requests. Without the macro, the zero word appears as instruction0=0 and fetch continues to address 4.
